// File: rtl/aes_axis_pkg.sv
// Shared types and constants for the AES-256 AXI-Stream accelerator data path.
package aes_axis_pkg;

  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned BLOCK_BYTES = 16;
  localparam int unsigned WORD_BYTES  = 4;
  localparam int unsigned BLK_CNT_W   = 16;

  typedef struct packed {
    logic [WORD_BYTES*BYTE_W-1:0] data;
    logic [WORD_BYTES-1:0]        keep;
    logic                         last;
  } axis_word_t;

  // Contiguous keep mask covering byte lanes 0..idx.
  function automatic logic [WORD_BYTES-1:0] keep_for_idx(input logic [1:0] idx);
    logic [WORD_BYTES-1:0] k;
    case (idx)
      2'd0:    k = 4'b0001;
      2'd1:    k = 4'b0011;
      2'd2:    k = 4'b0111;
      default: k = 4'b1111;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/axis_fifo2.sv
// Two-entry registered FIFO of packed AXI-Stream words; head entry is always in head_q.
module axis_fifo2
  import aes_axis_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  axis_word_t push_word,
  input  logic       pop,
  output axis_word_t head,
  output logic [1:0] cnt
);

  axis_word_t head_q, head_d;
  axis_word_t tail_q, tail_d;
  logic [1:0] cnt_q, cnt_d;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    unique case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = push_word;
        else               tail_d = push_word;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        // Simultaneous push/pop keeps occupancy; the new word lands behind whatever remains.
        if (cnt_q == 2'd1) begin
          head_d = push_word;
        end else begin
          head_d = tail_q;
          tail_d = push_word;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head = head_q;
  assign cnt  = cnt_q;

endmodule

// File: rtl/axis_byte_packer.sv
// Packs a byte-per-beat AXI-Stream into little-endian 32-bit words, counting frames and flagging short ones.
module axis_byte_packer
  import aes_axis_pkg::*;
#(
  parameter int unsigned C_AXIS_TDATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic [3:0]                    m_axis_tkeep,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [15:0]                   blk_count,
  output logic                          err_partial
);

  logic [1:0]                       idx_q, idx_d;
  logic [WORD_BYTES*BYTE_W-1:0]     acc_q, acc_d;
  logic [BLK_CNT_W-1:0]             blk_count_q, blk_count_d;
  logic                             err_partial_q, err_partial_d;

  logic [BYTE_W-1:0] in_byte;
  logic              s_acc;
  logic              commit;
  logic              pop;
  logic [1:0]        fifo_cnt;
  axis_word_t        word;
  axis_word_t        head;
  logic              unused_tdata_hi;

  assign in_byte         = s_axis_tdata[BYTE_W-1:0];
  assign unused_tdata_hi = ^s_axis_tdata[C_AXIS_TDATA_WIDTH-1:BYTE_W];

  // Ready and valid come straight from FIFO occupancy so neither depends on the opposite handshake.
  assign s_axis_tready = (fifo_cnt != 2'd2);
  assign m_axis_tvalid = (fifo_cnt != 2'd0);
  assign s_acc         = s_axis_tvalid & s_axis_tready;
  assign commit        = s_acc & ((idx_q == 2'd3) | s_axis_tlast);
  assign pop           = m_axis_tvalid & m_axis_tready;

  always_comb begin
    word.data = '0;
    for (int unsigned b = 0; b < WORD_BYTES; b++) begin
      if (b < 32'(idx_q))       word.data[b*BYTE_W +: BYTE_W] = acc_q[b*BYTE_W +: BYTE_W];
      else if (b == 32'(idx_q)) word.data[b*BYTE_W +: BYTE_W] = in_byte;
    end
    word.keep = keep_for_idx(idx_q);
    word.last = s_axis_tlast;
  end

  always_comb begin
    idx_d         = idx_q;
    acc_d         = acc_q;
    blk_count_d   = blk_count_q;
    err_partial_d = err_partial_q;
    if (s_acc) begin
      // The assembled word already holds every byte seen so far, so it doubles as the new accumulator.
      acc_d = word.data;
      idx_d = commit ? 2'd0 : idx_q + 2'd1;
      if (s_axis_tlast && (idx_q != 2'd3)) err_partial_d = 1'b1;
    end
    if (pop && head.last) blk_count_d = blk_count_q + BLK_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q         <= '0;
      acc_q         <= '0;
      blk_count_q   <= '0;
      err_partial_q <= 1'b0;
    end else begin
      idx_q         <= idx_d;
      acc_q         <= acc_d;
      blk_count_q   <= blk_count_d;
      err_partial_q <= err_partial_d;
    end
  end

  axis_fifo2 u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (commit),
    .push_word (word),
    .pop       (pop),
    .head      (head),
    .cnt       (fifo_cnt)
  );

  assign m_axis_tdata = head.data;
  assign m_axis_tkeep = head.keep;
  assign m_axis_tlast = head.last;
  assign blk_count    = blk_count_q;
  assign err_partial  = err_partial_q;

endmodule

// File: tb/tb_axis_byte_packer.sv
// Self-checking bench for axis_byte_packer: directed table, corner sequences and a queue-based reference model.
module tb_axis_byte_packer;
  import aes_axis_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [15:0] blk_count;
  logic        err_partial;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axis_byte_packer #(.C_AXIS_TDATA_WIDTH(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .blk_count     (blk_count),
    .err_partial   (err_partial)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: committed-but-unpopped words and bytes of the word being assembled.
  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } mword_t;

  mword_t      mq[$];
  logic [7:0]  pend[$];
  logic [15:0] m_blk = '0;
  logic        m_err = 1'b0;
  logic [15:0] blk_bias = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      mq.delete();
      pend.delete();
      m_blk = '0;
      m_err = 1'b0;
      chk("mon_rst_s_tready", s_axis_tready, 1);
      chk("mon_rst_m_tvalid", m_axis_tvalid, 0);
      chk("mon_rst_m_tdata", m_axis_tdata, 0);
      chk("mon_rst_m_tkeep", m_axis_tkeep, 0);
      chk("mon_rst_m_tlast", m_axis_tlast, 0);
      chk("mon_rst_blk", blk_count, 0);
      chk("mon_rst_err", err_partial, 0);
    end else begin
      mword_t w;
      logic   pop_m, acc_m;
      chk("mon_s_tready", s_axis_tready, mq.size() != 2);
      chk("mon_m_tvalid", m_axis_tvalid, mq.size() != 0);
      if (mq.size() != 0) begin
        chk("mon_m_tdata", m_axis_tdata, mq[0].data);
        chk("mon_m_tkeep", m_axis_tkeep, mq[0].keep);
        chk("mon_m_tlast", m_axis_tlast, mq[0].last);
      end
      chk("mon_blk", blk_count, 16'(m_blk + blk_bias));
      chk("mon_err", err_partial, m_err);
      pop_m = (mq.size() != 0) && m_axis_tready;
      acc_m = s_axis_tvalid && (mq.size() != 2);
      if (pop_m) begin
        if (mq[0].last) m_blk = m_blk + 16'd1;
        void'(mq.pop_front());
      end
      if (acc_m) begin
        pend.push_back(s_axis_tdata[7:0]);
        if (pend.size() == 4 || s_axis_tlast) begin
          w.data = '0;
          foreach (pend[k]) w.data = w.data | (32'(pend[k]) << (8 * k));
          w.keep = 4'((1 << pend.size()) - 1);
          w.last = s_axis_tlast;
          if (s_axis_tlast && pend.size() != 4) m_err = 1'b1;
          mq.push_back(w);
          pend.delete();
        end
      end
    end
  end

  task automatic stream_frame(input int base, input int n, output int nwords,
                              output logic [31:0] first_word);
    int nb;
    nb = 0;
    nwords = 0;
    first_word = '0;
    m_axis_tready = 1'b1;
    for (int c = 0; c < 4 * n + 20 && (nb < n || m_axis_tvalid); c++) begin
      logic acc;
      if (nb < n) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'(base + nb);
        s_axis_tlast  = (nb == n - 1);
      end else begin
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
      end
      acc = s_axis_tvalid & s_axis_tready;
      if (m_axis_tvalid) begin
        if (nwords == 0) first_word = m_axis_tdata;
        nwords++;
      end
      step();
      if (acc) nb++;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  din;
    logic        dlast;
    logic        exp_word;
    logic [31:0] exp_data;
    logic [3:0]  exp_keep;
    logic        exp_last;
  } vec_t;

  vec_t        vecs[22];
  logic [31:0] basic_words[4];
  logic [31:0] bp_words[4];
  logic [31:0] got[$];
  int          n_acc, nb, nwords;
  logic [31:0] first_word;
  logic        acc;

  initial begin
    rst_n         = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;

    basic_words = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
    bp_words    = '{32'h13121110, 32'h17161514, 32'h1B1A1918, 32'h1F1E1D1C};
    for (int unsigned i = 0; i < BLOCK_BYTES; i++) begin
      vecs[i].din      = 8'(i);
      vecs[i].dlast    = (i == BLOCK_BYTES - 1);
      vecs[i].exp_word = (i % 4 == 3);
      vecs[i].exp_data = basic_words[i / 4];
      vecs[i].exp_keep = 4'hF;
      vecs[i].exp_last = (i == BLOCK_BYTES - 1);
    end
    vecs[16] = '{8'hAA, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
    vecs[17] = '{8'hBB, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
    vecs[18] = '{8'hCC, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
    vecs[19] = '{8'hDD, 1'b0, 1'b1, 32'hDDCCBBAA, 4'hF, 1'b0};
    vecs[20] = '{8'hEE, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
    vecs[21] = '{8'hFF, 1'b1, 1'b1, 32'h0000FFEE, 4'h3, 1'b1};

    step();
    step();
    chk("rst_s_tready", s_axis_tready, 1);
    chk("rst_m_tvalid", m_axis_tvalid, 0);
    chk("rst_m_tdata", m_axis_tdata, 0);
    chk("rst_m_tkeep", m_axis_tkeep, 0);
    chk("rst_m_tlast", m_axis_tlast, 0);
    chk("rst_blk", blk_count, 0);
    chk("rst_err", err_partial, 0);
    rst_n = 1'b1;
    step();

    // Basic packing followed by a short frame, one byte per cycle with the sink always ready.
    m_axis_tready = 1'b1;
    foreach (vecs[i]) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = {24'($urandom), vecs[i].din};
      s_axis_tlast  = vecs[i].dlast;
      chk("tbl_s_tready", s_axis_tready, 1);
      step();
      chk("tbl_m_tvalid", m_axis_tvalid, vecs[i].exp_word);
      if (vecs[i].exp_word) begin
        chk("tbl_m_tdata", m_axis_tdata, vecs[i].exp_data);
        chk("tbl_m_tkeep", m_axis_tkeep, vecs[i].exp_keep);
        chk("tbl_m_tlast", m_axis_tlast, vecs[i].exp_last);
      end
      if (i == BLOCK_BYTES - 1) begin
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        step();
        chk("basic_blk", blk_count, 1);
        chk("basic_err", err_partial, 0);
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    step();
    chk("short_blk", blk_count, 2);
    chk("short_err", err_partial, 1);
    step();
    step();
    chk("short_err_sticky", err_partial, 1);

    // Backpressure: sink stalled while bytes keep coming.
    m_axis_tready = 1'b0;
    n_acc = 0;
    nb    = 0;
    s_axis_tvalid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      s_axis_tdata = 32'h10 + 32'(nb);
      s_axis_tlast = (nb == 15);
      acc = s_axis_tready;
      step();
      if (acc) begin
        n_acc++;
        nb++;
      end
    end
    chk("bp_accepted", 32'(n_acc), 8);
    chk("bp_s_tready_low", s_axis_tready, 0);
    m_axis_tready = 1'b1;
    got.delete();
    for (int c = 0; c < 60 && (nb < 16 || m_axis_tvalid); c++) begin
      if (nb < 16) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'h10 + 32'(nb);
        s_axis_tlast  = (nb == 15);
      end else begin
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
      end
      acc = s_axis_tvalid & s_axis_tready;
      if (m_axis_tvalid) got.push_back(m_axis_tdata);
      step();
      if (acc) nb++;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    chk("bp_word_count", 32'(got.size()), 4);
    for (int i = 0; i < 4; i++) chk("bp_word", (i < got.size()) ? got[i] : 32'hDEAD_BEEF, bp_words[i]);

    // Commit and pop in the same cycle with one word already buffered.
    m_axis_tready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 32'h40 + 32'(i);
      s_axis_tlast  = 1'b0;
      step();
    end
    chk("cp_pre_cnt", dut.u_fifo.cnt, 1);
    m_axis_tready = 1'b1;
    s_axis_tdata  = 32'h47;
    s_axis_tlast  = 1'b1;
    step();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    chk("cp_cnt", dut.u_fifo.cnt, 1);
    chk("cp_s_tready", s_axis_tready, 1);
    chk("cp_m_tvalid", m_axis_tvalid, 1);
    chk("cp_m_tdata", m_axis_tdata, 32'h47464544);
    chk("cp_m_tlast", m_axis_tlast, 1);
    step();
    step();

    // Reset in the middle of a word.
    for (int i = 0; i < 2; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 32'h50 + 32'(i);
      step();
    end
    s_axis_tvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_m_tvalid", m_axis_tvalid, 0);
    chk("mid_rst_s_tready", s_axis_tready, 1);
    chk("mid_rst_blk", blk_count, 0);
    chk("mid_rst_err", err_partial, 0);
    step();
    rst_n = 1'b1;
    step();
    stream_frame(32'h20, 16, nwords, first_word);
    chk("mid_rst_words", 32'(nwords), 4);
    chk("mid_rst_first", first_word, 32'h23222120);
    chk("mid_rst_blk_after", blk_count, 1);

    // Block counter wrap.
    force dut.blk_count_q = 16'hFFFF;
    blk_bias = 16'hFFFF - m_blk;
    #1;
    release dut.blk_count_q;
    step();
    chk("wrap_pre", blk_count, 16'hFFFF);
    stream_frame(32'h60, 16, nwords, first_word);
    chk("wrap_blk", blk_count, 16'h0000);

    // Randomized traffic checked by the reference model.
    for (int c = 0; c < 3000; c++) begin
      s_axis_tvalid = ($urandom_range(0, 3) != 0);
      s_axis_tdata  = $urandom;
      s_axis_tlast  = ($urandom_range(0, 11) == 0);
      m_axis_tready = ($urandom_range(0, 3) != 0);
      step();
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    for (int c = 0; c < 6; c++) step();
    chk("rand_drained", m_axis_tvalid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
